// File: rtl/led_array_pkg.sv
// Shared types and limits for the LED matrix scanner.
package led_array_pkg;

   localparam int MAX_ROWS = 32;
   localparam int MAX_COLS = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_DRIVE
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Binary-to-one-hot decoder with enable; all outputs low when disabled.
module decoder_onehot #(
   parameter  int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         ena,
   input  logic [W-1:0] sel,
   output logic [N-1:0] onehot
);

   // Raise exactly the selected line while enabled.
   always_comb begin
      // NOTE: default first so every path assigns onehot and no latch is inferred.
      onehot = '0;
      if (ena) begin
         for (int i = 0; i < N; i++) begin
            onehot[i] = (sel == W'(i));
         end
      end
   end

endmodule

// File: rtl/led_array_scanner.sv
// Double-buffered, self-timed LED matrix scanner with blanking between columns.
module led_array_scanner
   import led_array_pkg::*;
#(
   parameter  int ROWS        = 8,
   parameter  int COLS        = 8,
   parameter  int DWELL_TICKS = 1000,
   parameter  int BLANK_TICKS = 16,
   localparam int XW          = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [ROWS*COLS-1:0] in_cells,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ROWS-1:0]      rows,
   output logic [COLS-1:0]      cols,
   output logic [XW-1:0]        x,
   output logic                 frame_done
);

   localparam int             N           = ROWS * COLS;
   localparam int             TW          = $clog2(max_int(DWELL_TICKS, BLANK_TICKS) + 1);
   localparam logic [TW-1:0]  DWELL_LAST  = TW'(DWELL_TICKS - 1);
   localparam logic [TW-1:0]  BLANK_LAST  = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
   localparam logic [XW-1:0]  X_LAST      = XW'(COLS - 1);
   // With no blanking the scanner goes straight from column to column.
   localparam state_e         AFTER_DRIVE = (BLANK_TICKS == 0) ? S_DRIVE : S_BLANK;

   // Reject unusable geometry or timing at elaboration.
   if (ROWS < 1 || ROWS > MAX_ROWS) begin : g_bad_rows
      $error("led_array_scanner: ROWS out of range 1..32");
   end
   if (COLS < 1 || COLS > MAX_COLS) begin : g_bad_cols
      $error("led_array_scanner: COLS out of range 1..32");
   end
   if (DWELL_TICKS < 1) begin : g_bad_dwell
      $error("led_array_scanner: DWELL_TICKS must be >= 1");
   end
   if (BLANK_TICKS < 0) begin : g_bad_blank
      $error("led_array_scanner: BLANK_TICKS must be >= 0");
   end

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [XW-1:0]   x_q, x_d;
   logic [N-1:0]    pending_q, pending_d;
   logic [N-1:0]    active_q, active_d;
   logic            pending_full_q, pending_full_d;
   logic            in_ready_q, in_ready_d;
   logic [ROWS-1:0] rows_q, rows_d;
   logic [COLS-1:0] cols_q, cols_d;
   logic            frame_done_q, frame_done_d;
   logic            swap;
   logic            load;

   // Scan sequencing: state, dwell/blank timer, column index and frame-boundary swap request.
   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      x_d          = x_q;
      frame_done_d = 1'b0;
      swap         = 1'b0;
      if (!ena) begin
         state_d = S_IDLE;
         tick_d  = '0;
         x_d     = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               swap    = 1'b1;
               state_d = (BLANK_TICKS == 0) ? S_DRIVE : S_BLANK;
               tick_d  = '0;
               x_d     = '0;
            end
            S_BLANK: begin
               if (tick_q == BLANK_LAST) begin
                  state_d = S_DRIVE;
                  tick_d  = '0;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            S_DRIVE: begin
               if (tick_q == DWELL_LAST) begin
                  state_d = AFTER_DRIVE;
                  tick_d  = '0;
                  if (x_q == X_LAST) begin
                     x_d          = '0;
                     frame_done_d = 1'b1;
                     swap         = 1'b1;
                  end else begin
                     x_d = x_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               tick_d  = '0;
               x_d     = '0;
            end
         endcase
      end
   end

   // Frame buffering: a swap sees only the pending flag from the start of the cycle,
   // so a frame loaded on a boundary cycle waits for the following boundary.
   always_comb begin
      load           = in_valid && in_ready_q;
      pending_d      = load ? in_cells : pending_q;
      active_d       = active_q;
      pending_full_d = pending_full_q;
      if (swap && pending_full_q) begin
         active_d       = pending_q;
         pending_full_d = 1'b0;
      end
      if (load) begin
         pending_full_d = 1'b1;
      end
      in_ready_d = !pending_full_d;
   end

   decoder_onehot #(.N(COLS)) u_col_dec (
      .ena    (state_d == S_DRIVE),
      .sel    (x_d),
      .onehot (cols_d)
   );

   // Row drive: a row is pulled low when its cell in the lit column is set.
   always_comb begin
      rows_d = '1;
      for (int r = 0; r < ROWS; r++) begin
         rows_d[r] = ~(|(active_d[r*COLS +: COLS] & cols_d));
      end
   end

   // State and output registers; reset also clears both frame buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q        <= S_IDLE;
         tick_q         <= '0;
         x_q            <= '0;
         pending_q      <= '0;
         active_q       <= '0;
         pending_full_q <= 1'b0;
         in_ready_q     <= 1'b1;
         rows_q         <= '1;
         cols_q         <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_q         <= tick_d;
         x_q            <= x_d;
         pending_q      <= pending_d;
         active_q       <= active_d;
         pending_full_q <= pending_full_d;
         in_ready_q     <= in_ready_d;
         rows_q         <= rows_d;
         cols_q         <= cols_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign rows       = rows_q;
   assign cols       = cols_q;
   assign x          = x_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_array_scanner.sv
// Directed bench for led_array_scanner: main 4x5 array, a no-blank 1x3 array and a 1x1 array.
module tb_led_array_scanner;

   logic clk;
   logic rst;

   // Main instance: ROWS=4, COLS=5, DWELL=3, BLANK=1 (column period 4, frame period 20).
   logic        ena_m, in_valid_m, in_ready_m, fd_m;
   logic [19:0] in_cells_m;
   logic [3:0]  rows_m;
   logic [4:0]  cols_m;
   logic [2:0]  x_m;

   // No-blank instance: ROWS=1, COLS=3, DWELL=1, BLANK=0.
   logic        ena_n, in_valid_n, in_ready_n, fd_n;
   logic [2:0]  in_cells_n;
   logic [0:0]  rows_n;
   logic [2:0]  cols_n;
   logic [1:0]  x_n;

   // Single-cell instance: ROWS=1, COLS=1, DWELL=2, BLANK=1.
   logic        ena_o, in_valid_o, in_ready_o, fd_o;
   logic [0:0]  in_cells_o;
   logic [0:0]  rows_o;
   logic [0:0]  cols_o;
   logic [0:0]  x_o;

   int n_vec = 0;
   int n_err = 0;

   led_array_scanner #(.ROWS(4), .COLS(5), .DWELL_TICKS(3), .BLANK_TICKS(1)) u_main (
      .clk(clk), .rst(rst), .ena(ena_m), .in_cells(in_cells_m), .in_valid(in_valid_m),
      .in_ready(in_ready_m), .rows(rows_m), .cols(cols_m), .x(x_m), .frame_done(fd_m)
   );

   led_array_scanner #(.ROWS(1), .COLS(3), .DWELL_TICKS(1), .BLANK_TICKS(0)) u_nb (
      .clk(clk), .rst(rst), .ena(ena_n), .in_cells(in_cells_n), .in_valid(in_valid_n),
      .in_ready(in_ready_n), .rows(rows_n), .cols(cols_n), .x(x_n), .frame_done(fd_n)
   );

   led_array_scanner #(.ROWS(1), .COLS(1), .DWELL_TICKS(2), .BLANK_TICKS(1)) u_one (
      .clk(clk), .rst(rst), .ena(ena_o), .in_cells(in_cells_o), .in_valid(in_valid_o),
      .in_ready(in_ready_o), .rows(rows_o), .cols(cols_o), .x(x_o), .frame_done(fd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Expected main-array outputs k cycles after enabling, for a frame lit only at (1,2).
   task automatic check_main_bit7(input int k);
      int p, col;
      bit blank;
      p     = (k - 1) % 20;
      col   = p / 4;
      blank = (p % 4) == 0;
      check($sformatf("m_cols k=%0d", k), 32'(cols_m), blank ? 32'd0 : 32'(1 << col));
      check($sformatf("m_rows k=%0d", k), 32'(rows_m), (!blank && col == 2) ? 32'hD : 32'hF);
      check($sformatf("m_x k=%0d", k), 32'(x_m), 32'(col));
      check($sformatf("m_fd k=%0d", k), 32'(fd_m), (k > 1 && p == 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      ena_m      = 1'b0; in_valid_m = 1'b0; in_cells_m = '0;
      ena_n      = 1'b0; in_valid_n = 1'b0; in_cells_n = '0;
      ena_o      = 1'b0; in_valid_o = 1'b0; in_cells_o = '0;
      step();
      step();

      // Reset state.
      check("rst_rows", 32'(rows_m), 32'hF);
      check("rst_cols", 32'(cols_m), 32'h0);
      check("rst_x", 32'(x_m), 32'h0);
      check("rst_fd", 32'(fd_m), 32'h0);
      check("rst_ready", 32'(in_ready_m), 32'h1);
      rst = 1'b0;

      // Single lit cell (r1,c2): visible only during column 2 drive.
      in_cells_m = 20'h00080;
      in_valid_m = 1'b1;
      step();
      in_valid_m = 1'b0;
      check("load_ready_low", 32'(in_ready_m), 32'h0);
      check("idle_cols", 32'(cols_m), 32'h0);
      ena_m = 1'b1;
      for (int k = 1; k <= 41; k++) begin
         step();
         check_main_bit7(k);
         if (k == 1) check("swap_ready_high", 32'(in_ready_m), 32'h1);
      end

      // Frame A shown, frame B loaded mid-frame and shown only after the next boundary.
      ena_m = 1'b0;
      do_reset();
      in_cells_m = 20'h00001;
      in_valid_m = 1'b1;
      step();
      in_valid_m = 1'b0;
      ena_m = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (k == 2)  check("ab_A_col0", 32'(rows_m), 32'hE);
         if (k == 6)  check("ab_ready_low", 32'(in_ready_m), 32'h0);
         if (k == 18) check("ab_A_col4", 32'(rows_m), 32'hF);
         if (k == 20) check("ab_ready_still_low", 32'(in_ready_m), 32'h0);
         if (k == 21) check("ab_ready_back", 32'(in_ready_m), 32'h1);
         if (k == 21) check("ab_fd", 32'(fd_m), 32'h1);
         if (k == 22) check("ab_B_col0", 32'(rows_m), 32'hF);
         if (k == 38) check("ab_B_col4", 32'(rows_m), 32'h7);
         if (k == 5) begin
            in_cells_m = 20'h80000;
            in_valid_m = 1'b1;
         end
         if (k == 6) in_valid_m = 1'b0;
      end

      // Drop ena while column 3 is lit, then restart.
      ena_m = 1'b0;
      do_reset();
      ena_m = 1'b1;
      for (int k = 1; k <= 14; k++) step();
      check("off_pre_x", 32'(x_m), 32'h3);
      check("off_pre_cols", 32'(cols_m), 32'h08);
      ena_m = 1'b0;
      step();
      check("off_cols", 32'(cols_m), 32'h0);
      check("off_rows", 32'(rows_m), 32'hF);
      check("off_x", 32'(x_m), 32'h0);
      check("off_fd", 32'(fd_m), 32'h0);
      step();
      check("off_hold_x", 32'(x_m), 32'h0);
      ena_m = 1'b1;
      step();
      check("reon_blank_cols", 32'(cols_m), 32'h0);
      check("reon_blank_x", 32'(x_m), 32'h0);
      step();
      check("reon_col0", 32'(cols_m), 32'h01);

      // Reset mid-dwell with a pending frame: neither buffer may ever be displayed.
      ena_m = 1'b0;
      do_reset();
      in_cells_m = 20'hFFFFF;
      in_valid_m = 1'b1;
      step();
      in_valid_m = 1'b0;
      ena_m = 1'b1;
      step();
      in_valid_m = 1'b1;
      step();
      in_valid_m = 1'b0;
      check("rstm_pending", 32'(in_ready_m), 32'h0);
      check("rstm_lit", 32'(rows_m), 32'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstm_ready", 32'(in_ready_m), 32'h1);
      check("rstm_rows", 32'(rows_m), 32'hF);
      check("rstm_cols", 32'(cols_m), 32'h0);
      check("rstm_x", 32'(x_m), 32'h0);
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("rstm_dark k=%0d", k), 32'(rows_m), 32'hF);
         if (k == 2) check("rstm_scanning", 32'(cols_m), 32'h01);
      end

      // No-blank 1x3 and single-cell 1x1 arrays run side by side.
      ena_m = 1'b0;
      do_reset();
      in_cells_n = 3'b010;
      in_cells_o = 1'b1;
      in_valid_n = 1'b1;
      in_valid_o = 1'b1;
      step();
      in_valid_n = 1'b0;
      in_valid_o = 1'b0;
      ena_n = 1'b1;
      ena_o = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         int cn, po;
         step();
         cn = (k - 1) % 3;
         po = (k - 1) % 3;
         check($sformatf("nb_cols k=%0d", k), 32'(cols_n), 32'(1 << cn));
         check($sformatf("nb_rows k=%0d", k), 32'(rows_n), (cn == 1) ? 32'd0 : 32'd1);
         check($sformatf("nb_x k=%0d", k), 32'(x_n), 32'(cn));
         check($sformatf("nb_fd k=%0d", k), 32'(fd_n), (k > 1 && cn == 0) ? 32'd1 : 32'd0);
         check($sformatf("one_cols k=%0d", k), 32'(cols_o), (po == 0) ? 32'd0 : 32'd1);
         check($sformatf("one_rows k=%0d", k), 32'(rows_o), (po == 0) ? 32'd1 : 32'd0);
         check($sformatf("one_x k=%0d", k), 32'(x_o), 32'd0);
         check($sformatf("one_fd k=%0d", k), 32'(fd_o), (k > 1 && po == 0) ? 32'd1 : 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
